// File: rtl/microseq_pkg.sv
// Shared microcode field layout, sequencing encodings and fixed vectors for microseq.
package microseq_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'b000,
    SEQ_NEXT   = 3'b001,
    SEQ_FINISH = 3'b010,
    SEQ_SAVE   = 3'b011,
    SEQ_CALL   = 3'b100,
    SEQ_RET    = 3'b101
  } seq_e;

  // Control word field positions
  localparam int unsigned SEQ_LSB  = 0;
  localparam int unsigned SEQ_W    = 3;
  localparam int unsigned WE_BIT   = 3;
  localparam int unsigned LDM_BIT  = 4;
  localparam int unsigned FIN_LSB  = 5;
  localparam int unsigned NEXT_LSB = 16;

  localparam int unsigned FIN_PREFIX = 2;
  localparam int unsigned VEC_BASE   = 'h1F0;
  localparam int unsigned VEC_STRIDE = 4;
  localparam int unsigned RESET_VEC  = 'h1FC;

endpackage

// File: rtl/int_prio.sv
// NMI edge latch plus fixed-priority selection across NMI and level IRQs.
module int_prio
  import microseq_pkg::*;
#(
  parameter int unsigned NINT = 2,
  parameter int unsigned CHW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NINT-1:0] int_req,
  input  logic            iflag,
  input  logic            take,
  output logic            valid_c,
  output logic [CHW-1:0]  ch_c,
  output logic [NINT-1:0] ack_c
);

  logic            nmi_q, nmi_d;
  logic            nmi_prev_q, nmi_prev_d;
  logic [NINT-1:0] pend;

  always_comb begin
    pend    = '0;
    valid_c = 1'b0;
    ch_c    = '0;
    ack_c   = '0;
    pend[0] = nmi_q;
    for (int k = 1; k < int'(NINT); k++) begin
      pend[k] = int_req[k] & ~iflag;
    end
    // Scan downward so the lowest pending index wins
    for (int k = int'(NINT) - 1; k >= 0; k--) begin
      if (pend[k]) begin
        valid_c = 1'b1;
        ch_c    = CHW'(k);
      end
    end
    if (valid_c) begin
      ack_c[ch_c] = 1'b1;
    end
    // A fresh edge in the take cycle keeps the latch set
    nmi_d      = (nmi_q & ~(take & nmi_q)) | (int_req[0] & ~nmi_prev_q);
    nmi_prev_d = int_req[0];
    if (reset) begin
      nmi_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    nmi_q      <= nmi_d;
    nmi_prev_q <= nmi_prev_d;
  end

endmodule

// File: rtl/microseq.sv
// Microcode sequencer: next-address selection for a synchronous microcode ROM with interrupts.
module microseq
  import microseq_pkg::*;
#(
  parameter int unsigned CW    = 32,
  parameter int unsigned AW    = 9,
  parameter int unsigned FW    = 5,
  parameter int unsigned NINT  = 2,
  parameter int unsigned DBANK = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rdy,
  input  logic [7:0]      db,
  input  logic            dflag,
  input  logic            iflag,
  input  logic [NINT-1:0] int_req,
  output logic [AW-1:0]   uaddr,
  input  logic [CW-1:0]   udata,
  output logic [CW-1:0]   ctrl,
  output logic            sync,
  output logic            we,
  output logic            ld_m,
  output logic [NINT-1:0] int_ack
);

  localparam int unsigned CHW = (NINT > 1) ? $clog2(NINT) : 1;
  localparam int unsigned NW  = AW - 2;
  localparam int unsigned PW  = AW - 2 - FW;

  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   link_q, link_d;
  logic [FW-1:0]   fin_q, fin_d;
  logic            we_q, we_d;

  seq_e            seq;
  logic [NW-1:0]   next_f;
  logic [FW-1:0]   fin_f;
  logic            bank;
  logic            take;
  logic            valid_c;
  logic [CHW-1:0]  ch_c;
  logic [NINT-1:0] ack_c;

  int_prio #(
    .NINT (NINT),
    .CHW  (CHW)
  ) u_int_prio (
    .clk     (clk),
    .reset   (reset),
    .int_req (int_req),
    .iflag   (iflag),
    .take    (take),
    .valid_c (valid_c),
    .ch_c    (ch_c),
    .ack_c   (ack_c)
  );

  always_comb begin
    seq     = seq_e'(udata[SEQ_LSB +: SEQ_W]);
    next_f  = NW'(udata >> NEXT_LSB);
    fin_f   = FW'(udata >> FIN_LSB);
    bank    = (DBANK == 1) ? dflag : 1'b0;
    sync    = ~reset & (seq == SEQ_FETCH);
    take    = sync & rdy;
    int_ack = take ? ack_c : '0;
    ld_m    = udata[LDM_BIT] & rdy;
    ctrl    = udata;
    we      = we_q;

    // Stalled: re-present the held address so the ROM output stays put
    uaddr  = addr_q;
    link_d = link_q;
    fin_d  = fin_q;
    we_d   = we_q;

    if (reset) begin
      uaddr  = AW'(RESET_VEC);
      link_d = AW'(RESET_VEC);
      fin_d  = '0;
      we_d   = 1'b0;
    end else if (rdy) begin
      we_d = udata[WE_BIT];
      case (seq)
        SEQ_FETCH: begin
          if (valid_c) begin
            uaddr = AW'(VEC_BASE + VEC_STRIDE * 32'(ch_c));
          end else begin
            uaddr = AW'(db);
          end
        end
        SEQ_FINISH: uaddr = {1'b1, bank, PW'(FIN_PREFIX), fin_q};
        SEQ_SAVE: begin
          uaddr = {1'b1, bank, next_f};
          fin_d = fin_f;
        end
        SEQ_CALL: begin
          uaddr  = {1'b1, bank, next_f};
          link_d = addr_q + AW'(1);
        end
        SEQ_RET: uaddr = link_q;
        default: uaddr = {1'b1, bank, next_f};
      endcase
    end
    addr_d = uaddr;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    link_q <= link_d;
    fin_q  <= fin_d;
    we_q   <= we_d;
  end

endmodule

// File: tb/tb_microseq.sv
// Directed bench for microseq with a behavioural ROM/sequencer model checked every cycle.
module tb_microseq;

  logic        clk = 1'b0;
  logic        reset, rdy, dflag, iflag;
  logic [7:0]  db;
  logic [1:0]  int_req;
  logic [8:0]  uaddr;
  logic [31:0] udata, ctrl;
  logic        sync, we, ld_m;
  logic [1:0]  int_ack;

  logic [31:0] rom [512];

  int checks   = 0;
  int failures = 0;

  // Model state
  int   m_cur, m_link, m_fin;
  bit   m_nmi, m_prev, m_we, started;

  always #5 clk = ~clk;

  microseq dut (
    .clk     (clk),
    .reset   (reset),
    .rdy     (rdy),
    .db      (db),
    .dflag   (dflag),
    .iflag   (iflag),
    .int_req (int_req),
    .uaddr   (uaddr),
    .udata   (udata),
    .ctrl    (ctrl),
    .sync    (sync),
    .we      (we),
    .ld_m    (ld_m),
    .int_ack (int_ack)
  );

  always @(posedge clk) udata <= rom[uaddr];

  function automatic logic [31:0] mk(int seq, int wbit, int ldm, int fin, int nxt);
    return 32'((seq & 7) | ((wbit & 1) << 3) | ((ldm & 1) << 4) | ((fin & 'h1F) << 5) | ((nxt & 'h7F) << 16));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle model: expected outputs from the sequencing rules, then state advance
  always @(negedge clk) begin
    logic [31:0] w;
    int seq, nxt, fin, bnk, ch, exp_u;
    bit exp_sync;
    int exp_ack;
    w   = rom[m_cur];
    seq = int'(w & 7);
    nxt = int'((w >> 16) & 'h7F);
    fin = int'((w >> 5) & 'h1F);
    bnk = dflag ? 1 : 0;
    ch  = -1;
    if (m_nmi) ch = 0;
    else if (int_req[1] && !iflag) ch = 1;
    exp_sync = !reset && seq == 0;
    if (reset)       exp_u = 'h1FC;
    else if (!rdy)   exp_u = m_cur;
    else if (seq == 0) exp_u = (ch >= 0) ? 'h1F0 + 4 * ch : int'(db);
    else if (seq == 2) exp_u = 'h100 + 'h80 * bnk + 'h40 + m_fin;
    else if (seq == 5) exp_u = m_link;
    else             exp_u = 'h100 + 'h80 * bnk + nxt;
    exp_ack = (exp_sync && rdy && ch >= 0) ? (1 << ch) : 0;
    if (started) begin
      chk("model_uaddr", 32'(uaddr), 32'(exp_u));
      chk("model_sync", 32'(sync), 32'(exp_sync));
      chk("model_int_ack", 32'(int_ack), 32'(exp_ack));
      chk("model_we", 32'(we), 32'(m_we));
      chk("model_ld_m", 32'(ld_m), 32'(w[4] & rdy));
      chk("model_ctrl", ctrl, w);
    end
    if (reset) begin
      m_cur = 'h1FC; m_link = 'h1FC; m_fin = 0; m_we = 0; m_nmi = 0;
      started = 1;
    end else begin
      m_nmi = (m_nmi && exp_ack != 1) || (int_req[0] && !m_prev);
      if (rdy) begin
        if (seq == 3) m_fin = fin;
        if (seq == 4) m_link = (m_cur + 1) % 512;
        m_we  = w[3];
        m_cur = exp_u;
      end
    end
    m_prev = int_req[0];
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 32'h0;
    rom['h1FC] = mk(0, 0, 0, 0, 0);
    rom['h0A9] = mk(1, 1, 0, 0, 'h20);
    rom['h120] = mk(4, 0, 1, 0, 'h10);
    rom['h110] = mk(5, 1, 0, 0, 0);
    rom['h121] = mk(3, 0, 0, 3, 'h22);
    rom['h122] = mk(2, 1, 1, 0, 0);
    rom['h143] = mk(7, 0, 0, 0, 'h7E);
    rom['h17E] = mk(0, 1, 0, 0, 0);
    rom['h055] = mk(3, 0, 0, 3, 'h30);
    rom['h1B0] = mk(2, 0, 0, 0, 0);
    rom['h1F0] = mk(0, 1, 0, 0, 0);
    started = 0; m_prev = 0; m_nmi = 0; m_we = 0; m_cur = 0; m_link = 0; m_fin = 0;

    reset = 1; rdy = 1; db = 8'h00; dflag = 0; iflag = 1; int_req = 2'b00;
    cyc(2); #1;
    chk("reset_uaddr", 32'(uaddr), 32'h1FC);
    chk("reset_sync", 32'(sync), 32'h0);
    chk("reset_ack", 32'(int_ack), 32'h0);
    chk("reset_we", 32'(we), 32'h0);

    cyc(1); reset = 0; db = 8'hA9; #1;
    chk("first_ctrl", ctrl, 32'h0);
    chk("fetch_a9", 32'(uaddr), 32'h0A9);
    chk("fetch_sync", 32'(sync), 32'h1);
    cyc(1); #1;
    chk("next_120", 32'(uaddr), 32'h120);
    cyc(1); #1;
    chk("call_110", 32'(uaddr), 32'h110);
    chk("call_ld_m", 32'(ld_m), 32'h1);
    chk("we_prev", 32'(we), 32'h1);
    cyc(1); #1;
    chk("ret_121", 32'(uaddr), 32'h121);
    cyc(1); #1;
    chk("save_122", 32'(uaddr), 32'h122);
    cyc(1); #1;
    chk("finish_b0", 32'(uaddr), 32'h143);
    cyc(1); #1;
    chk("seq7_next", 32'(uaddr), 32'h17E);

    cyc(1); dflag = 1; db = 8'h55; #1;
    chk("fetch_55", 32'(uaddr), 32'h055);
    cyc(1); #1;
    chk("save_b1", 32'(uaddr), 32'h1B0);
    cyc(1); int_req = 2'b01; #1;
    chk("finish_1c3", 32'(uaddr), 32'h1C3);

    cyc(1); int_req = 2'b11; iflag = 0; #1;
    chk("nmi_vec", 32'(uaddr), 32'h1F0);
    chk("nmi_ack", 32'(int_ack), 32'h1);
    cyc(1); #1;
    chk("irq_vec", 32'(uaddr), 32'h1F4);
    chk("irq_ack", 32'(int_ack), 32'h2);

    for (int i = 0; i < 3; i++) begin
      cyc(1); rdy = 0; #1;
      chk("stall_uaddr", 32'(uaddr), 32'h1F4);
      chk("stall_ack", 32'(int_ack), 32'h0);
      chk("stall_ctrl", ctrl, 32'h0);
    end
    cyc(1); rdy = 1; #1;
    chk("unstall_vec", 32'(uaddr), 32'h1F4);
    chk("unstall_ack", 32'(int_ack), 32'h2);

    cyc(1); int_req = 2'b00; iflag = 1; dflag = 0; db = 8'hA9; #1;
    chk("refetch_a9", 32'(uaddr), 32'h0A9);
    chk("refetch_ack", 32'(int_ack), 32'h0);
    cyc(1); int_req = 2'b01; #1;
    chk("seq2_120", 32'(uaddr), 32'h120);
    cyc(1); #1;
    chk("seq2_we", 32'(we), 32'h1);
    cyc(1); reset = 1; #1;
    chk("midreset_uaddr", 32'(uaddr), 32'h1FC);
    chk("midreset_sync", 32'(sync), 32'h0);
    cyc(1); #1;
    chk("midreset_we", 32'(we), 32'h0);
    cyc(1); reset = 0; db = 8'hA9; #1;
    chk("post_reset_ctrl", ctrl, 32'h0);
    chk("no_stale_nmi", 32'(uaddr), 32'h0A9);
    chk("no_stale_ack", 32'(int_ack), 32'h0);

    cyc(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microseq.md
MICROSEQ -- requirements
Module: microseq

Interface
REQ-001 SHALL have parameter CW, default 32: control word width.
REQ-002 SHALL have parameter AW, default 9: microcode address width, minimum 9.
REQ-003 SHALL have parameter FW, default 5: finisher pointer width, at most AW-4.
REQ-004 SHALL have parameter NINT, default 2: interrupt channels; channel 0 is NMI.
REQ-005 SHALL have parameter DBANK, default 1: 1 = decimal flag selects the upper/lower microcode bank.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rdy, input, 1 bit: 0 stalls the sequencer.
REQ-009 SHALL have port db, input, 8 bits: data bus, used as opcode at sync.
REQ-010 SHALL have ports dflag and iflag, input, 1 bit each: processor D and I flags.
REQ-011 SHALL have port int_req, input, NINT bits: bit 0 is the NMI line; bits 1+ are level IRQs.
REQ-012 SHALL have port uaddr, output, AW bits: address to the external synchronous ROM (1-cycle read).
REQ-013 SHALL have port udata, input, CW bits: ROM data, used as the current control word.
REQ-014 SHALL have port ctrl, output, CW bits: udata passed through unchanged.
REQ-015 SHALL have ports sync, we and ld_m, output, 1 bit each: opcode fetch cycle, registered write enable, and memory load strobe.
REQ-016 SHALL have port int_ack, output, NINT bits: one-hot, 1-cycle pulse for the channel taken.

Function
REQ-017 SHALL decode the SEQ field (3 bits) as: 000 fetch, 001 next, 010 finish, 011 next plus save finisher, 100 call, 101 return; 110/111 act as next.
REQ-018 SHALL form the next address as follows (B = dflag when DBANK=1, else 0):
- fetch: {0, db}
- next or call: {1, B, NEXT}
- finish: {1, B, FIN_PREFIX, finish_reg}
- return: link_reg
REQ-019 SHALL load finish_reg from the FIN field on SEQ 011.
REQ-020 SHALL load link_reg with current address+1 (wraps modulo 2^AW) on SEQ 100, one level deep; a nested call overwrites it.
REQ-021 SHALL assert sync when SEQ=000 and reset=0.
REQ-022 SHALL keep an NMI latch set on a rising edge of int_req[0]; it clears only on the cycle the NMI is taken, and a new edge in that same cycle leaves it set.
REQ-023 SHALL treat IRQ channel k (k≥1) as pending while int_req[k]=1 and iflag=0.
REQ-024 SHALL, at sync with rdy=1, take the lowest-index pending channel instead of fetching: uaddr = VEC_BASE + ch*VEC_STRIDE, and int_ack[ch] pulses in that cycle.
REQ-025 SHALL, while rdy=0, drive uaddr = held address (the ROM re-reads, so ctrl is stable) and change no state except the NMI latch; it issues no int_ack.
REQ-026 SHALL drive we from the WE bit of the previous ctrl, updated only when rdy=1.
REQ-027 SHALL set ld_m = LDM bit & rdy.
REQ-028 SHALL ensure every next-address result comes from registered state or udata/db with no combinational path from uaddr.

Reset
REQ-029 SHALL, while reset=1, drive uaddr=RESET_VEC, and set held address and link_reg to RESET_VEC, finish_reg to 0, NMI latch to 0, we to 0, sync to 0 and int_ack to 0.
REQ-030 SHALL, on the first cycle after reset, have ctrl = ROM[RESET_VEC]; a reset mid-instruction abandons the current sequence and any pending NMI.

Structure
REQ-031 SHALL take SEQ encodings, field positions (SEQ, NEXT, FIN, WE, LDM), FIN_PREFIX, VEC_BASE, VEC_STRIDE and RESET_VEC from shared package microseq_pkg.
REQ-032 SHALL implement interrupt latching and priority selection in one sub-module, int_prio, which outputs a valid flag, a channel index and an ack vector.

Verification
REQ-033 SHALL cover: SEQ=000, db=8'hA9, dflag=0 -> next uaddr=9'h0A9 and sync=1.
REQ-034 SHALL cover: SEQ=011 with FIN=5'h03, then SEQ=010, dflag=1 -> uaddr=9'h1C3.
REQ-035 SHALL cover: call at address 9'h120 to NEXT=7'h10, then return -> uaddrs 9'h110 then 9'h121.
REQ-036 SHALL cover: NMI edge plus IRQ1 pending, iflag=0, at sync -> NMI vector and int_ack=2'b01; at the next sync -> IRQ vector and 2'b10.
REQ-037 SHALL cover: rdy=0 for 3 cycles at sync with IRQ pending -> uaddr and ctrl held, no ack; ack follows on the first rdy=1 cycle.
REQ-038 SHALL cover: reset asserted mid-sequence with NMI latched -> uaddr=RESET_VEC and we=0; no NMI taken afterwards.
